// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared state and route encodings for the 1-to-4 stream demux
package demux_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        RT_A = 2'd0,
        RT_B = 2'd1,
        RT_C = 2'd2,
        RT_D = 2'd3
    } route_t;

endpackage

// File: rtl/demux_1to4_stream_if.sv
// rtl/demux_1to4_stream_if.sv - input stream, four output streams and status of the demux
interface demux_1to4_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_last;
    logic               in_ready;
    logic               sel1;
    logic               sel2;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*CNT_W-1:0] beat_cnt;
    logic               busy;

    modport master (
        output in_data, in_valid, in_last, sel1, sel2, out_ready,
        input  in_ready, out_data, out_valid, beat_cnt, busy
    );

    modport slave (
        input  in_data, in_valid, in_last, sel1, sel2, out_ready,
        output in_ready, out_data, out_valid, beat_cnt, busy
    );
endinterface

// File: rtl/demux_out_buf.sv
// rtl/demux_out_buf.sv - one-entry output buffer with a wrapping delivered-beat counter
module demux_out_buf #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    // A load in the same cycle as a drain keeps valid high, giving one beat per clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            cnt   <= '0;
        end else begin
            if (load) begin
                data  <= load_data;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (valid && ready) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_1to4_stream.sv
// rtl/demux_1to4_stream.sv - burst-locked 1-to-4 stream demux with per-output buffers
module demux_1to4_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input logic               clk,
    input logic               rst,
    demux_1to4_stream_if.slave s
);

    state_t           state_q, state_d;
    route_t           route_q, route_d;
    route_t           cur_route;
    logic             in_ready;
    logic             xfer_in;
    logic [3:0]       buf_valid;
    logic [WIDTH-1:0] buf_data [4];
    logic [CNT_W-1:0] buf_cnt  [4];

    // Live select only steers the first beat of a burst; later beats use the latch.
    always_comb begin
        cur_route = route_t'({s.sel1, s.sel2});
        if (state_q == ST_BURST) begin
            cur_route = route_q;
        end
    end

    assign in_ready   = !rst && (!buf_valid[cur_route] || s.out_ready[cur_route]);
    assign xfer_in    = s.in_valid && in_ready;
    assign s.in_ready = in_ready;

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_in && !s.in_last) begin
                    state_d = ST_BURST;
                    route_d = cur_route;
                end
            end
            ST_BURST: begin
                if (xfer_in && s.in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            route_q <= RT_A;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_buf
        demux_out_buf #(
            .WIDTH(WIDTH),
            .CNT_W(CNT_W)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .load      (xfer_in && (cur_route == route_t'(gi))),
            .load_data (s.in_data),
            .ready     (s.out_ready[gi]),
            .valid     (buf_valid[gi]),
            .data      (buf_data[gi]),
            .cnt       (buf_cnt[gi])
        );
    end

    always_comb begin
        s.out_data = '0;
        s.beat_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            s.out_data[i*WIDTH +: WIDTH] = buf_data[i];
            s.beat_cnt[i*CNT_W +: CNT_W] = buf_cnt[i];
        end
    end

    assign s.out_valid = buf_valid;
    assign s.busy      = (state_q == ST_BURST);

endmodule

// File: tb/tb_demux_1to4_stream.sv
// tb/tb_demux_1to4_stream.sv - directed and random checks of demux_1to4_stream against a queue-level model
module tb_demux_1to4_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;

    demux_1to4_stream_if #(.WIDTH(8), .CNT_W(8)) bus ();

    demux_1to4_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .s   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Model: each output is a queue holding at most one beat plus its last-seen data.
    bit [7:0] m_q [4][$];
    bit [7:0] m_last [4];
    int       m_cnt  [4];
    bit       m_locked;
    bit [1:0] m_route;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i].delete();
            m_last[i] = 8'h00;
            m_cnt[i]  = 0;
        end
        m_locked = 0;
        m_route  = 2'd0;
    endtask

    task automatic cyc(input bit r, input bit v, input bit l, input bit [7:0] d,
                       input bit [1:0] sel, input bit [3:0] ordy, output bit acc);
        bit [1:0]  rt;
        bit        exp_rdy;
        bit [3:0]  exp_valid;
        bit [31:0] exp_data;
        bit [31:0] exp_cnt;
        rst          = r;
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
        bus.sel1     = sel[1];
        bus.sel2     = sel[0];
        bus.out_ready = ordy;
        #1;
        rt      = m_locked ? m_route : sel;
        exp_rdy = !r && (m_q[rt].size() == 0 || ordy[rt]);
        for (int i = 0; i < 4; i++) begin
            exp_valid[i]        = (m_q[i].size() != 0);
            exp_data[i*8 +: 8]  = m_last[i];
            exp_cnt[i*8 +: 8]   = 8'(m_cnt[i] % 256);
        end
        if (chk_en) begin
            check_eq("in_ready", bus.in_ready, exp_rdy);
            check_eq("out_valid", bus.out_valid, exp_valid);
            check_eq("out_data", bus.out_data, exp_data);
            check_eq("beat_cnt", bus.beat_cnt, exp_cnt);
            check_eq("busy", bus.busy, m_locked);
        end
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m_q[i].size() != 0 && ordy[i]) begin
                    void'(m_q[i].pop_front());
                    m_cnt[i]++;
                end
            end
            if (acc) begin
                m_q[rt].push_back(d);
                m_last[rt] = d;
                if (!m_locked && !l) begin
                    m_locked = 1;
                    m_route  = rt;
                end else if (m_locked && l) begin
                    m_locked = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit [3:0] ordy);
        bit acc;
        cyc(0, 0, 0, 8'h00, 2'd0, ordy, acc);
    endtask

    task automatic send(input bit [7:0] d, input bit [1:0] sel, input bit l, input bit [3:0] ordy);
        bit acc;
        int n;
        acc = 0;
        n   = 0;
        while (!acc && n < 16) begin
            cyc(0, 1, l, d, sel, ordy, acc);
            n++;
        end
        check_eq("send_accept", acc, 1'b1);
    endtask

    initial begin
        bit acc;
        bus.in_valid  = 0;
        bus.in_last   = 0;
        bus.in_data   = 0;
        bus.sel1      = 0;
        bus.sel2      = 0;
        bus.out_ready = 0;
        model_reset();

        // T1: reset held two clocks with in_valid asserted
        cyc(1, 1, 0, 8'hAA, 2'd0, 4'hF, acc);
        chk_en = 1;
        cyc(1, 1, 0, 8'hAA, 2'd0, 4'hF, acc);
        check_eq("t1_accept_in_reset", acc, 1'b0);
        idle(4'hF);

        // T2: single-beat bursts to each output
        send(8'h11, 2'd0, 1, 4'hF);
        send(8'h22, 2'd1, 1, 4'hF);
        send(8'h33, 2'd2, 1, 4'hF);
        send(8'h44, 2'd3, 1, 4'hF);
        idle(4'hF);
        check_eq("t2_beat_cnt", bus.beat_cnt, 32'h01010101);
        check_eq("t2_out_data", bus.out_data, 32'h44332211);

        // T3: burst locked to c while the select toggles
        for (int k = 0; k < 4; k++) begin
            send(8'hA0 + 8'(k), (k % 2 == 0) ? 2'd2 : 2'd1, k == 3, 4'hF);
            if (k < 3) check_eq("t3_busy", bus.busy, 1'b1);
        end
        check_eq("t3_busy_end", bus.busy, 1'b0);
        idle(4'hF);
        check_eq("t3_cnt_c", bus.beat_cnt[23:16], 8'd5);

        // T4: backpressure on b
        send(8'hB0, 2'd1, 0, 4'b1101);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 8'hB1, 2'd1, 4'b1101, acc);
            check_eq("t4_blocked", acc, 1'b0);
        end
        send(8'hB1, 2'd1, 0, 4'hF);
        send(8'hB2, 2'd1, 1, 4'hF);
        idle(4'hF);
        idle(4'hF);
        check_eq("t4_cnt_b", bus.beat_cnt[15:8], 8'd4);

        // T5: a held full while d keeps flowing
        send(8'h5A, 2'd0, 1, 4'b1110);
        for (int k = 0; k < 3; k++) send(8'hD0 + 8'(k), 2'd3, 1, 4'b1110);
        check_eq("t5_a_held", bus.out_valid[0], 1'b1);
        idle(4'hF);
        idle(4'hF);

        // T6: counter wrap on b, then reset in the middle of a burst
        cyc(1, 0, 0, 8'h00, 2'd0, 4'hF, acc);
        for (int k = 0; k < 257; k++) send(8'(k), 2'd1, 1, 4'hF);
        idle(4'hF);
        check_eq("t6_wrap", bus.beat_cnt[15:8], 8'd1);
        send(8'hE0, 2'd3, 0, 4'h0);
        send(8'hE1, 2'd3, 0, 4'hF);
        cyc(1, 0, 0, 8'h00, 2'd3, 4'h0, acc);
        check_eq("t6_busy_rst", bus.busy, 1'b0);
        check_eq("t6_valid_rst", bus.out_valid, 4'b0000);
        send(8'h77, 2'd0, 1, 4'hF);
        check_eq("t6_live_route", bus.out_valid, 4'b0001);
        idle(4'hF);

        // Random traffic
        for (int k = 0; k < 600; k++) begin
            cyc($urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 2) == 0,
                8'($urandom), 2'($urandom), 4'($urandom), acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
